regbank_fwd_unit: RTL and testbench
===================================

// Module: regbank_fwd_unit
// PURPOSE
//   Parametrised successor to the pipeline register bank. Combines the register file, a
//   destination scoreboard and forwarding-select generation in one block. Sits between
//   decode and the ALU. Operand forwarding from ans_ex/ans_dm/ans_wb is resolved inside
//   the block, and load-use (or any hazard when forwarding is disabled) raises stall.
// PARAMETERS
//   DATA_W    16  operand/result width
//   ADDR_W    5   register index width; NUM_REGS = 2**ADDR_W
//   ZERO_REG  1   1: reg 0 reads 0, writes to it dropped, never forwarded
//   FWD_EN    1   1: forward from EX/DM/WB; 0: no forwarding, stall until write-back
// PORTS
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous, active-high
//   issue_valid  in   1       decode presents an instruction this cycle
//   ra           in   ADDR_W  source A index
//   rb           in   ADDR_W  source B index (ignored for hazards when imm_sel=1)
//   rw           in   ADDR_W  destination index
//   wr_en        in   1       instruction writes rw
//   is_load      in   1       result appears first on ans_dm (not ans_ex)
//   imm_sel      in   1       B operand = imm
//   imm          in   DATA_W  immediate
//   ans_ex       in   DATA_W  ALU result (instruction issued 2 cycles earlier)
//   ans_dm       in   DATA_W  memory-stage result (issued 3 cycles earlier)
//   ans_wb       in   DATA_W  write-back result (issued 4 cycles earlier)
//   stall        out  1       issue not accepted; decode holds its inputs
//   a_out        out  DATA_W  operand A (valid the cycle after acceptance)
//   b_out        out  DATA_W  operand B
//   fwd_sel_a    out  2       00 RF, 01 EX, 10 DM, 11 WB (registered)
//   fwd_sel_b    out  2       same encoding for B; 00 when imm_sel
// BEHAVIOUR
//   - Issue is accepted when issue_valid & !stall.
//   - Scoreboard: slots S1..S4, each {vld, load, rd}. Slots shift S1->S2->S3->S4 on
//     every clock, independent of stall.
//   - S1 <= {accepted & wr_en & !(ZERO_REG & rw==0), is_load, rw}. A stall or idle
//     cycle inserts a bubble (vld=0).
//   - RF write: at the clock edge, if S4.vld then RF[S4.rd] <= ans_wb. Reads in the same
//     cycle are write-through (they see ans_wb).
//   - Match(r,Sk) = Sk.vld & Sk.rd==r & !(ZERO_REG & r==0).
//   - FWD_EN=1 select per source, priority S1>S2>S3:
//       S1 -> EX
//       S2 -> DM
//       S3 -> WB
//       otherwise RF (write-through read)
//   - FWD_EN=1 stall: issue_valid & Match(src,S1) & S1.load (load-use, 1 cycle).
//   - FWD_EN=0 stall: issue_valid & Match(src,S1|S2|S3); the selected value is always RF.
//   - stall is combinational from the inputs and slots, and is 0 when issue_valid=0.
//   - On acceptance, fwd_sel_a/fwd_sel_b, the RF read values (or imm) and the zero flags
//     are registered.
//   - Next cycle, a_out/b_out = combinational mux of the registered select over
//     ans_ex/ans_dm/ans_wb/registered RF value.
//   - When no issue is accepted, the output registers hold their values.
//   - Reset (synchronous, overrides issue): all slots vld=0, RF cleared to 0, fwd_sel=00,
//     registered values 0. Hence a_out=b_out=0 and stall=0 after reset.
//   - Reset mid-operation: in-flight results are discarded and never written.
//   - Same rd in several slots: the youngest (lowest k) wins.
//   - ra==rb: both sources receive identical selects.
// TESTING
//   1 reset, then issue ra=5, rb=6 -> next cycle a_out=b_out=0, fwd_sel=00, stall=0
//   2 issue r1<=.. at t0; issue ra=1 at t1 -> stall=0, fwd_sel_a=01 at t2,
//     a_out==ans_ex (drive 16'h1234)
//   3 load r3 at t0; issue ra=3 at t1 -> stall=1 at t1 only; accepted t2,
//     fwd_sel_a=10 at t3, a_out==ans_dm
//   4 write r4 at t0 and at t1; read r4 at t2 -> fwd_sel_a=01 (younger); at t3 read r4
//     -> 10
//   5 ZERO_REG=1: write r0 with ans_wb=16'hFFFF; read r0 -> fwd_sel 00, a_out=0
//   6 FWD_EN=0: write r7 at t0; read r7 presented t1 -> stall t1..t3, accepted t4,
//     a_out = t4 ans_wb value

Source files
------------

// File: rtl/regbank_fwd_unit.sv
// Register file with a four-slot destination scoreboard and operand forwarding-select logic.
// It sits between decode and the ALU and raises stall on load-use, or on any hazard when forwarding is off.
module regbank_fwd_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int FWD_EN   = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_issue_valid,
  input  logic [ADDR_W-1:0] i_ra,
  input  logic [ADDR_W-1:0] i_rb,
  input  logic [ADDR_W-1:0] i_rw,
  input  logic              i_wr_en,
  input  logic              i_is_load,
  input  logic              i_imm_sel,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [DATA_W-1:0] i_ans_ex,
  input  logic [DATA_W-1:0] i_ans_dm,
  input  logic [DATA_W-1:0] i_ans_wb,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_a_out,
  output logic [DATA_W-1:0] o_b_out,
  output logic [1:0]        o_fwd_sel_a,
  output logic [1:0]        o_fwd_sel_b
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic              vld;
    logic              load;
    logic [ADDR_W-1:0] rd;
  } head_slot_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] rd;
  } slot_t;

  // Handshake: an issue is taken when i_issue_valid && !o_stall; decode holds its inputs while stalled.
  head_slot_t        r_s1;
  slot_t             r_s2, r_s3, r_s4;
  logic [DATA_W-1:0] r_rf [NUM_REGS];
  logic [1:0]        r_sel_a, r_sel_b;
  logic [DATA_W-1:0] r_val_a, r_val_b;

  logic              w_m1_a, w_m2_a, w_m3_a;
  logic              w_m1_b, w_m2_b, w_m3_b;
  logic              w_haz_a, w_haz_b;
  logic              w_accept;
  logic [1:0]        w_sel_a, w_sel_b;
  logic [DATA_W-1:0] w_rd_a, w_rd_b, w_val_b;

  function automatic logic f_match(input logic [ADDR_W-1:0] r, input logic vld,
                                   input logic [ADDR_W-1:0] rd);
    f_match = vld && (rd == r) && !((ZERO_REG != 0) && (r == '0));
  endfunction

  // Youngest producer wins: S1 (EX) over S2 (DM) over S3 (WB).
  function automatic logic [1:0] f_sel(input logic m1, input logic m2, input logic m3);
    if (FWD_EN == 0) f_sel = 2'b00;
    else if (m1)     f_sel = 2'b01;
    else if (m2)     f_sel = 2'b10;
    else if (m3)     f_sel = 2'b11;
    else             f_sel = 2'b00;
  endfunction

  function automatic logic f_haz(input logic m1, input logic m2, input logic m3, input logic ld);
    if (FWD_EN != 0) f_haz = m1 && ld;
    else             f_haz = m1 || m2 || m3;
  endfunction

  function automatic logic [DATA_W-1:0] f_mux(input logic [1:0] sel, input logic [DATA_W-1:0] val,
                                              input logic [DATA_W-1:0] ex, input logic [DATA_W-1:0] dm,
                                              input logic [DATA_W-1:0] wb);
    case (sel)
      2'b01:   f_mux = ex;
      2'b10:   f_mux = dm;
      2'b11:   f_mux = wb;
      default: f_mux = val;
    endcase
  endfunction

  assign w_m1_a = f_match(i_ra, r_s1.vld, r_s1.rd);
  assign w_m2_a = f_match(i_ra, r_s2.vld, r_s2.rd);
  assign w_m3_a = f_match(i_ra, r_s3.vld, r_s3.rd);
  assign w_m1_b = f_match(i_rb, r_s1.vld, r_s1.rd);
  assign w_m2_b = f_match(i_rb, r_s2.vld, r_s2.rd);
  assign w_m3_b = f_match(i_rb, r_s3.vld, r_s3.rd);

  assign w_haz_a  = f_haz(w_m1_a, w_m2_a, w_m3_a, r_s1.load);
  assign w_haz_b  = !i_imm_sel && f_haz(w_m1_b, w_m2_b, w_m3_b, r_s1.load);
  assign o_stall  = i_issue_valid && (w_haz_a || w_haz_b);
  assign w_accept = i_issue_valid && !o_stall;

  assign w_sel_a = f_sel(w_m1_a, w_m2_a, w_m3_a);
  assign w_sel_b = i_imm_sel ? 2'b00 : f_sel(w_m1_b, w_m2_b, w_m3_b);

  // Write-through: a register retiring from S4 this cycle is read as i_ans_wb.
  assign w_rd_a = ((ZERO_REG != 0) && (i_ra == '0)) ? '0 :
                  (r_s4.vld && (r_s4.rd == i_ra)) ? i_ans_wb : r_rf[i_ra];
  assign w_rd_b = ((ZERO_REG != 0) && (i_rb == '0)) ? '0 :
                  (r_s4.vld && (r_s4.rd == i_rb)) ? i_ans_wb : r_rf[i_rb];
  assign w_val_b = i_imm_sel ? i_imm : w_rd_b;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_s4    <= '0;
      r_sel_a <= 2'b00;
      r_sel_b <= 2'b00;
      r_val_a <= '0;
      r_val_b <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else begin
      if (r_s4.vld) r_rf[r_s4.rd] <= i_ans_wb;
      r_s1.vld  <= w_accept && i_wr_en && !((ZERO_REG != 0) && (i_rw == '0));
      r_s1.load <= i_is_load;
      r_s1.rd   <= i_rw;
      r_s2      <= '{vld: r_s1.vld, rd: r_s1.rd};
      r_s3      <= r_s2;
      r_s4      <= r_s3;
      if (w_accept) begin
        r_sel_a <= w_sel_a;
        r_sel_b <= w_sel_b;
        r_val_a <= w_rd_a;
        r_val_b <= w_val_b;
      end
    end
  end

  assign o_fwd_sel_a = r_sel_a;
  assign o_fwd_sel_b = r_sel_b;
  assign o_a_out     = f_mux(r_sel_a, r_val_a, i_ans_ex, i_ans_dm, i_ans_wb);
  assign o_b_out     = f_mux(r_sel_b, r_val_b, i_ans_ex, i_ans_dm, i_ans_wb);

endmodule

// File: tb/tb_regbank_fwd_unit.sv
// Bench for regbank_fwd_unit: one forwarding and one non-forwarding instance share stimulus;
// a cycle-stamped write log plus a register array predicts both.
module tb_regbank_fwd_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iv = 1'b0, we = 1'b0, ld = 1'b0, ims = 1'b0;
  logic [4:0]  ra = '0, rb = '0, rw = '0;
  logic [15:0] imm = '0, ex = '0, dm = '0, wb = '0;

  logic        stall_f, stall_n;
  logic [15:0] a_f, b_f, a_n, b_n;
  logic [1:0]  sa_f, sb_f, sa_n, sb_n;

  always #5 clk = ~clk;

  regbank_fwd_unit #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1), .FWD_EN(1)) dut_f (
    .i_clk(clk), .i_reset(reset), .i_issue_valid(iv), .i_ra(ra), .i_rb(rb), .i_rw(rw),
    .i_wr_en(we), .i_is_load(ld), .i_imm_sel(ims), .i_imm(imm), .i_ans_ex(ex),
    .i_ans_dm(dm), .i_ans_wb(wb), .o_stall(stall_f), .o_a_out(a_f), .o_b_out(b_f),
    .o_fwd_sel_a(sa_f), .o_fwd_sel_b(sb_f));

  regbank_fwd_unit #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1), .FWD_EN(0)) dut_n (
    .i_clk(clk), .i_reset(reset), .i_issue_valid(iv), .i_ra(ra), .i_rb(rb), .i_rw(rw),
    .i_wr_en(we), .i_is_load(ld), .i_imm_sel(ims), .i_imm(imm), .i_ans_ex(ex),
    .i_ans_dm(dm), .i_ans_wb(wb), .o_stall(stall_n), .o_a_out(a_n), .o_b_out(b_n),
    .o_fwd_sel_a(sa_n), .o_fwd_sel_b(sb_n));

  // Reference model: accepted register writes tagged with the cycle they issued in.
  typedef struct packed {
    int         cyc;
    logic       inst;
    logic       ld;
    logic [4:0] rd;
  } wr_t;

  wr_t         log_q[$];
  int          now = 0;
  logic [15:0] m_rf [2][32];
  logic [1:0]  e_sa [2];
  logic [1:0]  e_sb [2];
  logic [15:0] e_va [2];
  logic [15:0] e_vb [2];

  int n_checks = 0;
  int n_fail = 0;

  logic        st_reset = 1'b0;
  logic [15:0] st_ex = '0, st_dm = '0, st_wb = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, now);
    end
  endtask

  // Age in cycles (1..3) of the youngest logged writer of r for instance i, 0 if none.
  function automatic void find_writer(input int i, input logic [4:0] r, output int age,
                                      output logic wld);
    age = 0;
    wld = 1'b0;
    if (r == 5'd0) return;
    foreach (log_q[j]) begin
      if (int'(log_q[j].inst) == i && log_q[j].rd == r) begin
        int d = now - log_q[j].cyc;
        if (d >= 1 && d <= 3 && (age == 0 || d < age)) begin
          age = d;
          wld = log_q[j].ld;
        end
      end
    end
  endfunction

  function automatic logic [15:0] rd_val(input int i, input logic [4:0] r);
    if (r == 5'd0) return 16'h0;
    foreach (log_q[j])
      if (int'(log_q[j].inst) == i && log_q[j].rd == r && now - log_q[j].cyc == 4) return wb;
    return m_rf[i][r];
  endfunction

  function automatic logic [15:0] pick(input logic [1:0] s, input logic [15:0] v);
    case (s)
      2'd1:    return ex;
      2'd2:    return dm;
      2'd3:    return wb;
      default: return v;
    endcase
  endfunction

  task automatic model_cycle();
    for (int i = 0; i < 2; i++) begin
      logic        o_st;
      logic [1:0]  o_sa, o_sb;
      logic [15:0] o_a, o_b;
      int          age_a, age_b;
      logic        ld_a, ld_b, st, acc;
      string       pre;
      pre = (i == 0) ? "fwd" : "nofwd";
      if (i == 0) begin
        o_st = stall_f; o_sa = sa_f; o_sb = sb_f; o_a = a_f; o_b = b_f;
      end else begin
        o_st = stall_n; o_sa = sa_n; o_sb = sb_n; o_a = a_n; o_b = b_n;
      end
      find_writer(i, ra, age_a, ld_a);
      find_writer(i, rb, age_b, ld_b);
      if (ims) age_b = 0;
      if (i == 0) st = iv && ((age_a == 1 && ld_a) || (age_b == 1 && ld_b));
      else        st = iv && (age_a != 0 || age_b != 0);
      if (!reset) begin
        check({pre, "_stall"}, 32'(o_st), 32'(st));
        check({pre, "_sel_a"}, 32'(o_sa), 32'(e_sa[i]));
        check({pre, "_sel_b"}, 32'(o_sb), 32'(e_sb[i]));
        check({pre, "_a_out"}, 32'(o_a), 32'(pick(e_sa[i], e_va[i])));
        check({pre, "_b_out"}, 32'(o_b), 32'(pick(e_sb[i], e_vb[i])));
      end
      if (reset) begin
        e_sa[i] = '0; e_sb[i] = '0; e_va[i] = '0; e_vb[i] = '0;
        for (int r = 0; r < 32; r++) m_rf[i][r] = '0;
      end else begin
        acc = iv && !st;
        if (acc) begin
          e_sa[i] = (i == 0) ? 2'(age_a) : 2'd0;
          e_va[i] = rd_val(i, ra);
          e_sb[i] = (i == 0 && !ims) ? 2'(age_b) : 2'd0;
          e_vb[i] = ims ? imm : rd_val(i, rb);
        end
        foreach (log_q[j])
          if (int'(log_q[j].inst) == i && now - log_q[j].cyc == 4) m_rf[i][log_q[j].rd] = wb;
        if (acc && we && rw != 5'd0) log_q.push_back('{cyc: now, inst: 1'(i), ld: ld, rd: rw});
      end
    end
    if (reset) log_q.delete();
    else
      for (int j = log_q.size() - 1; j >= 0; j--)
        if (now - log_q[j].cyc >= 4) log_q.delete(j);
    now++;
  endtask

  // One cycle: apply inputs after the falling edge, then check and advance the model.
  task automatic step(input logic v, input logic [4:0] a, input logic [4:0] b, input logic [4:0] w,
                      input logic wev, input logic ldv, input logic imsv, input logic [15:0] im);
    @(negedge clk);
    reset = st_reset; iv = v; ra = a; rb = b; rw = w; we = wev; ld = ldv; ims = imsv; imm = im;
    ex = st_ex; dm = st_dm; wb = st_wb;
    st_reset = 1'b0;
    st_ex = 16'($urandom); st_dm = 16'($urandom); st_wb = 16'($urandom);
    #1 model_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      e_sa[i] = '0; e_sb[i] = '0; e_va[i] = '0; e_vb[i] = '0;
      for (int r = 0; r < 32; r++) m_rf[i][r] = '0;
    end

    // Reset, then a plain issue of r5/r6
    st_reset = 1'b1; idle(1);
    st_reset = 1'b1; idle(1);
    idle(1);
    check("rst_stall", 32'(stall_f), 32'd0);
    check("rst_a_out", 32'(a_f), 32'd0);
    step(1'b1, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("t1_stall", 32'(stall_f), 32'd0);
    idle(1);
    check("t1_a_out", 32'(a_f), 32'd0);
    check("t1_b_out", 32'(b_f), 32'd0);
    check("t1_sel_a", 32'(sa_f), 32'd0);
    check("t1_sel_b", 32'(sb_f), 32'd0);

    // EX forward of r1
    idle(4);
    step(1'b1, 5'd2, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("t2_stall", 32'(stall_f), 32'd0);
    st_ex = 16'h1234; idle(1);
    check("t2_sel_a", 32'(sa_f), 32'd1);
    check("t2_a_out", 32'(a_f), 32'h1234);

    // Load-use on r3
    idle(4);
    step(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("t3_stall_t1", 32'(stall_f), 32'd1);
    step(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("t3_stall_t2", 32'(stall_f), 32'd0);
    st_dm = 16'hABCD; idle(1);
    check("t3_sel_a", 32'(sa_f), 32'd2);
    check("t3_a_out", 32'(a_f), 32'hABCD);

    // Two writers of r4: youngest wins
    idle(4);
    step(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    st_ex = 16'h1111;
    step(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("t4_sel_a_t3", 32'(sa_f), 32'd1);
    check("t4_a_out_t3", 32'(a_f), 32'h1111);
    st_dm = 16'h2222; idle(1);
    check("t4_sel_a_t4", 32'(sa_f), 32'd2);
    check("t4_a_out_t4", 32'(a_f), 32'h2222);

    // r0 is hardwired to zero
    idle(4);
    st_wb = 16'hFFFF; step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'h0);
    st_wb = 16'hFFFF; step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    st_wb = 16'hFFFF; idle(1);
    check("t5_sel_a_t2", 32'(sa_f), 32'd0);
    check("t5_a_out_t2", 32'(a_f), 32'd0);
    st_wb = 16'hFFFF; idle(1);
    st_wb = 16'hFFFF; step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    st_wb = 16'hFFFF; idle(1);
    check("t5_sel_a_t5", 32'(sa_f), 32'd0);
    check("t5_a_out_t5", 32'(a_f), 32'd0);

    // No-forwarding instance waits for write-back of r7
    idle(4);
    step(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
      check($sformatf("t6_stall_t%0d", k), 32'(stall_n), 32'd1);
    end
    st_wb = 16'h5A5A;
    step(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("t6_stall_t4", 32'(stall_n), 32'd0);
    st_wb = 16'h0000; idle(1);
    check("t6_sel_a", 32'(sa_n), 32'd0);
    check("t6_a_out", 32'(a_n), 32'h5A5A);
    check("t6_b_out", 32'(b_n), 32'h5A5A);

    // Randomized traffic on a small register window, with occasional resets
    for (int c = 0; c < 2000; c++) begin
      st_reset = ($urandom_range(0, 149) == 0);
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
